// File: rtl/sched_pkg.sv
// sched_pkg: shared FSM encoding and default sizing for slot_scheduler
package sched_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, BUSY} state_t;
  localparam int SLOT_W = 3;
  localparam int NUM_SLOTS_DEF = 6;
  localparam int HOLD_MAX_DEF = 15;
endpackage

// File: rtl/slot_counter.sv
// slot_counter: modulo-NUM_SLOTS slot index with step, load and registered wrap pulse
module slot_counter import sched_pkg::*; #(
  parameter int NUM_SLOTS = NUM_SLOTS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              load,
  input  logic [SLOT_W-1:0] load_val,
  output logic [SLOT_W-1:0] count,
  output logic              wrap
);
  localparam logic [SLOT_W-1:0] LAST = SLOT_W'(NUM_SLOTS - 1);
  logic [SLOT_W-1:0] count_q, count_d;
  logic wrap_q, wrap_d;
  // A load to a lower index means the jump passed through the last slot
  always_comb begin
    count_d = load ? load_val : inc ? (count_q == LAST ? '0 : count_q + 1'b1) : count_q;
    wrap_d = load ? load_val < count_q : inc && count_q == LAST;
  end
  always_ff @(posedge clk) begin
    count_q <= rst ? '0 : count_d;
    wrap_q <= rst ? 1'b0 : wrap_d;
  end
  assign count = count_q;
  assign wrap = wrap_q;
endmodule

// File: rtl/slot_scheduler.sv
// slot_scheduler: TDM slot arbiter with hold-time limit; define SLOT_SKIP_EN to jump
// straight to the next requesting slot instead of stepping one slot per cycle.
module slot_scheduler import sched_pkg::*; #(
  parameter int NUM_SLOTS = NUM_SLOTS_DEF,
  parameter int HOLD_MAX  = HOLD_MAX_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NUM_SLOTS-1:0] req,
  input  logic                 done,
  output logic [NUM_SLOTS-1:0] gnt,
  output logic [SLOT_W-1:0]    slot,
  output logic                 wrap,
  output logic                 timeout
);
  localparam logic [7:0] HOLD = 8'(HOLD_MAX);
  localparam logic [SLOT_W:0] NS = (SLOT_W + 1)'(NUM_SLOTS);
  state_t state_q, state_d;
  logic [NUM_SLOTS-1:0] gnt_q, gnt_d, rot;
  logic [7:0] cnt_q, cnt_d;
  logic timeout_q, timeout_d, inc, load, req_cur, end_grant;
  logic [SLOT_W-1:0] slot_q, skip, target;
  logic [SLOT_W:0] sum;
  slot_counter #(.NUM_SLOTS(NUM_SLOTS)) u_slot (
    .clk(clk), .rst(rst), .inc(inc), .load(load), .load_val(target),
    .count(slot_q), .wrap(wrap)
  );
  // rot[k] is the request of slot (slot+k) mod NUM_SLOTS; skip is the nearest k>0 requesting
  always_comb begin
    rot = NUM_SLOTS'({req, req} >> slot_q);
    skip = '0;
    for (int k = NUM_SLOTS - 1; k > 0; k--) skip = rot[k] ? SLOT_W'(k) : skip;
    sum = {1'b0, slot_q} + {1'b0, skip};
    target = sum >= NS ? SLOT_W'(sum - NS) : SLOT_W'(sum);
  end
  assign req_cur = rot[0];
  assign end_grant = done || !req_cur || cnt_q == HOLD;
  always_comb begin
    state_d = state_q == IDLE ? (en ? SCAN : IDLE)
            : state_q == SCAN ? (!en ? IDLE : req_cur ? BUSY : SCAN)
            : end_grant ? (en ? SCAN : IDLE) : BUSY;
  end
  always_comb begin
    gnt_d = '0;
    cnt_d = '0;
    timeout_d = 1'b0;
    inc = 1'b0;
    load = 1'b0;
    if (state_q == SCAN && en) begin
      gnt_d = req_cur ? NUM_SLOTS'(1) << slot_q : '0;
      cnt_d = req_cur ? 8'd1 : 8'd0;
`ifdef SLOT_SKIP_EN
      load = !req_cur && skip != '0;
      inc = !req_cur && skip == '0;
`else
      inc = !req_cur;
`endif
    end else if (state_q == BUSY) begin
      gnt_d = end_grant ? '0 : gnt_q;
      cnt_d = end_grant ? '0 : cnt_q + 8'd1;
      timeout_d = cnt_q == HOLD && !done && req_cur;
      inc = end_grant;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q <= '0;
      cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      cnt_q <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign gnt = gnt_q;
  assign slot = slot_q;
  assign timeout = timeout_q;
endmodule

// File: tb/tb_slot_scheduler.sv
// tb_slot_scheduler: directed and random checks of slot_scheduler against a behavioural model
module tb_slot_scheduler;
  localparam int N = 6;
  localparam int H = 4;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, done = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic [2:0] slot;
  logic wrap, timeout;
  int tests = 0, fails = 0, wraps = 0, tos = 0, gcnt = 0;
  int m_slot = 0, m_held = 0;
  bit m_act = 0, m_busy = 0, e_wrap = 0, e_to = 0;

  slot_scheduler #(.NUM_SLOTS(N), .HOLD_MAX(H)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .done(done),
    .gnt(gnt), .slot(slot), .wrap(wrap), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int next_slot();
`ifdef SLOT_SKIP_EN
    for (int k = 1; k < N; k++) if (req[(m_slot + k) % N]) return (m_slot + k) % N;
`endif
    return (m_slot + 1) % N;
  endfunction

  task automatic jump(input int to);
    e_wrap = to < m_slot;
    m_slot = to;
  endtask

  task automatic model();
    e_wrap = 0;
    e_to = 0;
    if (rst) begin
      m_slot = 0; m_held = 0; m_act = 0; m_busy = 0;
    end else if (m_busy) begin
      if (done || !req[m_slot] || m_held == H) begin
        e_to = !done && req[m_slot];
        m_busy = 0; m_held = 0; m_act = en;
        jump((m_slot + 1) % N);
      end else m_held++;
    end else if (m_act) begin
      if (!en) m_act = 0;
      else if (req[m_slot]) begin m_busy = 1; m_held = 1; end
      else jump(next_slot());
    end else m_act = en;
  endtask

  task automatic step();
    @(posedge clk);
    model();
    #1;
    check("gnt", gnt, m_busy ? 32'd1 << m_slot : 32'd0);
    check("slot", slot, m_slot);
    check("wrap", wrap, e_wrap);
    check("timeout", timeout, e_to);
    wraps += int'(wrap);
    tos += int'(timeout);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    wraps = 0;
    tos = 0;
  endtask

  task automatic wait_grant();
    for (int i = 0; i < 20; i++) begin
      if (gnt != '0) break;
      step();
    end
    check("grant_wait", gnt != '0, 1);
  endtask

  initial begin
    // reset state
    do_reset();
    check("rst_gnt", gnt, 0);
    check("rst_slot", slot, 0);
    // single requester, done on the third grant cycle
    en = 1'b1; req = 6'b000001;
    do_reset();
    step();
    check("scan_no_gnt", gnt, 0);
    step();
    check("gnt0_latency", gnt, 6'b000001);
    step(); step();
    done = 1'b1;
    step();
    done = 1'b0;
    check("done_release", gnt, 0);
    check("slot_after_done", slot, 1);
    // requester at the last slot, wrap on release
    req = 6'b100000;
    do_reset();
    wait_grant();
    check("gnt5", gnt, 6'b100000);
    check("slot5", slot, 5);
    done = 1'b1;
    step();
    done = 1'b0;
    check("wrap_once", wraps, 1);
    check("slot_wrapped", slot, 0);
    // hold limit forces release
    req = 6'b000100;
    do_reset();
    wait_grant();
    gcnt = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (gnt == '0) break;
      gcnt++;
    end
    check("hold_cycles", gcnt, H);
    check("timeout_once", tos, 1);
    check("slot_after_timeout", slot, 3);
    // done coinciding with the hold limit suppresses timeout
    do_reset();
    wait_grant();
    repeat (H - 1) step();
    done = 1'b1;
    step();
    done = 1'b0;
    check("done_vs_timeout", timeout, 0);
    check("done_vs_timeout_gnt", gnt, 0);
    check("no_timeout_seen", tos, 0);
    // reset in the middle of a grant
    do_reset();
    wait_grant();
    step();
    rst = 1'b1;
    step();
    check("rst_busy_gnt", gnt, 0);
    check("rst_busy_slot", slot, 0);
    rst = 1'b0; en = 1'b0;
    step();
    check("idle_after_rst", gnt, 0);
    // enable drops mid-grant: grant completes, then idle
    en = 1'b1;
    do_reset();
    wait_grant();
    en = 1'b0;
    step(); step();
    check("en_drop_hold", gnt, 6'b000100);
    done = 1'b1;
    step();
    done = 1'b0;
    step(); step();
    check("idle_slot_kept", slot, 3);
    check("idle_no_gnt", gnt, 0);
`ifdef SLOT_SKIP_EN
    // jump from slot 4 across the wrap to slot 1
    en = 1'b1; req = 6'b001000;
    do_reset();
    wait_grant();
    req = 6'b000010;
    step();
    check("skip_from", slot, 4);
    step();
    check("skip_slot", slot, 1);
    check("skip_wrap", wrap, 1);
    step();
    check("skip_gnt", gnt, 6'b000010);
`endif
    // random traffic
    for (int i = 0; i < 600; i++) begin
      rst = $urandom_range(0, 59) == 0;
      en = $urandom_range(0, 9) != 0;
      req = N'($urandom & $urandom);
      done = $urandom_range(0, 5) == 0;
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/slot_scheduler.md
SLOT_SCHEDULER -- requirements
Module: slot_scheduler

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 6, giving the number of requesters and TDM slots (range 2..8).
REQ-002 SHALL have parameter HOLD_MAX, default 15, giving the maximum grant length in cycles before forced release (range 1..255).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit: scheduler enable.
REQ-006 SHALL have port req, input, NUM_SLOTS bits: per-requester request; bit i belongs to slot i.
REQ-007 SHALL have port done, input, 1 bit: the current grantee releases the resource.
REQ-008 SHALL have port gnt, output, NUM_SLOTS bits: registered grant; one-hot or zero.
REQ-009 SHALL have port slot, output, 3 bits: current slot index, 0..NUM_SLOTS-1.
REQ-010 SHALL have port wrap, output, 1 bit: one-cycle pulse when slot advances from NUM_SLOTS-1 to 0.
REQ-011 SHALL have port timeout, output, 1 bit: one-cycle pulse when a grant is forced off by HOLD_MAX.

Function
REQ-012 SHALL implement FSM states IDLE, SCAN, BUSY.
REQ-013 SHALL move IDLE->SCAN when en=1; SCAN->IDLE when en=0 (slot retained).
REQ-014 SHALL, in SCAN with req[slot]=1, assert gnt[slot] on the next edge and enter BUSY (1-cycle request-to-grant latency).
REQ-015 SHALL, in SCAN with req[slot]=0, advance slot by 1 modulo NUM_SLOTS per cycle.
REQ-016 SHALL hold gnt constant in BUSY and count the cycles of the grant from 1.
REQ-017 SHALL end BUSY on the edge where done=1, or req[slot]=0, or count=HOLD_MAX; gnt clears on that edge, slot advances by 1, and the FSM returns to SCAN (IDLE if en=0).
REQ-018 SHALL pulse timeout only when the grant ends by count=HOLD_MAX with done=0 and req[slot]=1; done takes priority over timeout in the same cycle.
REQ-019 SHALL complete a grant already in progress when en drops during BUSY, then enter IDLE.
REQ-020 SHALL pulse wrap on every 5->0 (NUM_SLOTS-1 -> 0) advance, from SCAN or from BUSY exit.
REQ-021 SHALL never assert more than one gnt bit and never assert gnt outside BUSY.

Reset
REQ-022 SHALL, on rst=1 at a clock edge, set state=IDLE, slot=0, gnt=0, wrap=0, timeout=0, and the hold count=0, in any state including mid-grant.
REQ-023 SHALL give rst priority over en, req and done.

Configuration
REQ-024 SHALL provide macro SLOT_SKIP_EN; when it is defined, SCAN jumps in one cycle to the first requesting slot found in circular order starting at the current slot, and grants it on the next edge.
REQ-025 SHALL, with SLOT_SKIP_EN defined, pulse wrap when the jump crosses slot NUM_SLOTS-1 -> 0.
REQ-026 SHALL, with SLOT_SKIP_EN undefined, advance slot strictly one step per SCAN cycle, as in REQ-015.

Structure
REQ-027 SHALL place the state enum, SLOT_W=3 and the default NUM_SLOTS/HOLD_MAX constants in shared package sched_pkg.
REQ-028 SHALL implement the slot index as sub-module slot_counter: a modulo-NUM_SLOTS counter with inputs inc and load and a load value, and outputs count and wrap.

Verification
REQ-029 SHALL cover: rst, en=1, req=6'b000001, done at the 3rd grant cycle -> gnt=000001 one cycle after SCAN entry, held 3 cycles, then slot=1.
REQ-030 SHALL cover: req=6'b100000 with no skip -> slot steps 0..5, gnt=100000 at slot 5, and wrap pulses once when the grant is released.
REQ-031 SHALL cover: HOLD_MAX=4, req[2] held, done=0 -> gnt[2] for exactly 4 cycles, timeout pulses once, slot=3.
REQ-032 SHALL cover: done=1 and count=HOLD_MAX in the same cycle -> grant released and timeout=0.
REQ-033 SHALL cover: rst during BUSY with gnt=000100 -> next cycle gnt=0, slot=0, state IDLE.
REQ-034 SHALL cover: SLOT_SKIP_EN defined, slot=4, req=6'b000010 -> slot=1 after one cycle, wrap=1, gnt=000010 on the following cycle.
